// File: rtl/vm_vend_ctrl.sv
// Vending sequencer: collects coin credit, requests one item at PRICE, then pays change one coin per handshake.
// Optional build macro VM_SOLDOUT_EN adds a soldout input that blocks or refunds a sale.
module vm_vend_ctrl #(
    parameter int PRICE = 3,
    parameter int CW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          coin_a,
    input  logic          coin_b,
    input  logic          cancel,
`ifdef VM_SOLDOUT_EN
    input  logic          soldout,
`endif
    output logic          coin_rej,
    output logic [CW-1:0] credit,
    output logic          item_req,
    input  logic          item_ack,
    output logic          chg_req,
    output logic [1:0]    chg_val,
    input  logic          chg_ack,
    output logic          busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_VEND    = 2'd2,
        ST_CHANGE  = 2'd3
    } state_t;

    localparam logic [CW-1:0] PRICE_C = CW'(PRICE);

    state_t          r_state;
    logic [CW-1:0]   r_credit;
    logic            r_item_req;
    logic            r_chg_req;
    logic [1:0]      r_chg_val;
    logic            r_coin_rej;
    logic            r_busy;

    state_t          w_state_nxt;
    logic [CW-1:0]   w_credit_nxt;
    logic            w_item_req_nxt;
    logic            w_chg_req_nxt;
    logic [1:0]      w_chg_val_nxt;
    logic            w_coin_rej_nxt;
    logic            w_busy_nxt;

    logic            w_soldout;
    logic            w_any_coin;
    logic [CW-1:0]   w_coin_add;
    logic [CW-1:0]   w_acc;
    logic [CW-1:0]   w_left;

    // Largest coin that does not exceed the remaining credit.
    function automatic logic [1:0] chg_coin(input logic [CW-1:0] c);
        if (c >= CW'(2)) begin
            return 2'd2;
        end else begin
            return 2'd1;
        end
    endfunction

`ifdef VM_SOLDOUT_EN
    assign w_soldout = soldout;
`else
    assign w_soldout = 1'b0;
`endif

    assign w_any_coin = coin_a | coin_b;
    assign w_coin_add = {{(CW-2){1'b0}}, coin_b, coin_a};

    // Next-state, next-credit and next-output decode.
    always_comb begin
        w_state_nxt    = r_state;
        w_credit_nxt   = r_credit;
        w_item_req_nxt = r_item_req;
        w_chg_req_nxt  = r_chg_req;
        w_chg_val_nxt  = r_chg_val;
        w_coin_rej_nxt = 1'b0;
        w_acc          = r_credit;
        w_left         = r_credit;

        case (r_state)
            ST_IDLE, ST_COLLECT: begin
                // A soldout machine with no credit refuses coins outright.
                if ((r_state == ST_IDLE) && w_soldout) begin
                    w_acc          = r_credit;
                    w_coin_rej_nxt = w_any_coin;
                end else begin
                    w_acc = r_credit + w_coin_add;
                end
                w_credit_nxt = w_acc;
                if (cancel) begin
                    if (w_acc != {CW{1'b0}}) begin
                        w_state_nxt   = ST_CHANGE;
                        w_chg_req_nxt = 1'b1;
                        w_chg_val_nxt = chg_coin(w_acc);
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (w_acc >= PRICE_C) begin
                    if (w_soldout) begin
                        w_state_nxt   = ST_CHANGE;
                        w_chg_req_nxt = 1'b1;
                        w_chg_val_nxt = chg_coin(w_acc);
                    end else begin
                        w_state_nxt    = ST_VEND;
                        w_item_req_nxt = 1'b1;
                    end
                end else if (w_acc != {CW{1'b0}}) begin
                    w_state_nxt = ST_COLLECT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_VEND: begin
                w_coin_rej_nxt = w_any_coin;
                if (r_item_req && item_ack) begin
                    w_left         = r_credit - PRICE_C;
                    w_credit_nxt   = w_left;
                    w_item_req_nxt = 1'b0;
                    if (w_left != {CW{1'b0}}) begin
                        w_state_nxt   = ST_CHANGE;
                        w_chg_req_nxt = 1'b1;
                        w_chg_val_nxt = chg_coin(w_left);
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_state_nxt = ST_VEND;
                end
            end
            ST_CHANGE: begin
                w_coin_rej_nxt = w_any_coin;
                if (r_chg_req) begin
                    if (chg_ack) begin
                        w_left        = r_credit - {{(CW-2){1'b0}}, r_chg_val};
                        w_credit_nxt  = w_left;
                        w_chg_req_nxt = 1'b0;
                        w_chg_val_nxt = 2'd0;
                        if (w_left == {CW{1'b0}}) begin
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_state_nxt = ST_CHANGE;
                        end
                    end else begin
                        w_state_nxt = ST_CHANGE;
                    end
                end else if (r_credit != {CW{1'b0}}) begin
                    // Request is re-raised after the mandatory one-cycle gap.
                    w_chg_req_nxt = 1'b1;
                    w_chg_val_nxt = chg_coin(r_credit);
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_credit_nxt   = {CW{1'b0}};
                w_item_req_nxt = 1'b0;
                w_chg_req_nxt  = 1'b0;
                w_chg_val_nxt  = 2'd0;
            end
        endcase

        w_busy_nxt = (w_state_nxt == ST_VEND) || (w_state_nxt == ST_CHANGE);
    end

    // State and registered-output update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_credit   <= {CW{1'b0}};
            r_item_req <= 1'b0;
            r_chg_req  <= 1'b0;
            r_chg_val  <= 2'd0;
            r_coin_rej <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_credit   <= w_credit_nxt;
            r_item_req <= w_item_req_nxt;
            r_chg_req  <= w_chg_req_nxt;
            r_chg_val  <= w_chg_val_nxt;
            r_coin_rej <= w_coin_rej_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    assign credit   = r_credit;
    assign item_req = r_item_req;
    assign chg_req  = r_chg_req;
    assign chg_val  = r_chg_val;
    assign coin_rej = r_coin_rej;
    assign busy     = r_busy;

endmodule

// File: tb/tb_vm_vend_ctrl.sv
// Directed scoreboard bench for vm_vend_ctrl (PRICE=3, CW=4).
module tb_vm_vend_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       coin_a = 1'b0;
    logic       coin_b = 1'b0;
    logic       cancel = 1'b0;
    logic       item_ack = 1'b0;
    logic       chg_ack = 1'b0;
    logic       coin_rej;
    logic [3:0] credit;
    logic       item_req;
    logic       chg_req;
    logic [1:0] chg_val;
    logic       busy;
`ifdef VM_SOLDOUT_EN
    logic       soldout = 1'b0;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    logic [9:0] exp_q[$];

    vm_vend_ctrl #(.PRICE(3), .CW(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .coin_a   (coin_a),
        .coin_b   (coin_b),
        .cancel   (cancel),
`ifdef VM_SOLDOUT_EN
        .soldout  (soldout),
`endif
        .coin_rej (coin_rej),
        .credit   (credit),
        .item_req (item_req),
        .item_ack (item_ack),
        .chg_req  (chg_req),
        .chg_val  (chg_val),
        .chg_ack  (chg_ack),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Pop the oldest expectation and compare it with {credit,item_req,chg_req,chg_val,coin_rej,busy}.
    task automatic check(input string tag);
        logic [9:0] exp_v;
        logic [9:0] obs_v;
        exp_v = exp_q.pop_front();
        obs_v = {credit, item_req, chg_req, chg_val, coin_rej, busy};
        n_chk = n_chk + 1;
        assert (obs_v === exp_v) n_pass = n_pass + 1;
        else $error("FAIL %s observed cr=%0d ir=%b cq=%b cv=%0d rej=%b busy=%b expected cr=%0d ir=%b cq=%b cv=%0d rej=%b busy=%b",
                    tag, obs_v[9:6], obs_v[5], obs_v[4], obs_v[3:2], obs_v[1], obs_v[0],
                    exp_v[9:6], exp_v[5], exp_v[4], exp_v[3:2], exp_v[1], exp_v[0]);
    endtask

    // Drive one cycle of inputs, queue the outputs expected after the edge, then check them.
    task automatic step(input string tag, input logic a, input logic b, input logic c,
                        input logic ia, input logic ca,
                        input logic [3:0] ecr, input logic eir, input logic ecq,
                        input logic [1:0] ecv, input logic erej, input logic ebusy);
        coin_a   = a;
        coin_b   = b;
        cancel   = c;
        item_ack = ia;
        chg_ack  = ca;
        exp_q.push_back({ecr, eir, ecq, ecv, erej, ebusy});
        @(posedge clk);
        #1;
        check(tag);
    endtask

    initial begin
        // reset held for two cycles
        @(posedge clk);
        @(posedge clk);
        #1;
        exp_q.push_back(10'd0);
        check("reset");
        rst = 1'b1;

        // a, a, b -> 1,2,4, vend, one coin of change
        step("s1_a1",   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        step("s1_a2",   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        step("s1_b",    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
        step("s1_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
        step("s1_iack", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1);
        step("s1_cack", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);

        // b, b -> 2,4, vend, change of exactly 1; stray acks in IDLE ignored
        step("s2_b1",   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        step("s2_b2",   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
        step("s2_iack", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1);
        step("s2_cack", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        step("s2_stray",1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);

        // a+b in one cycle -> exact price, no change
        step("s3_ab",   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
        step("s3_iack", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        step("s3_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);

        // b then cancel -> refund coin of 2 held stable while unacked
        step("s4_b",    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        step("s4_can",  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step("s4_wait", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1);
        end
        step("s4_cack", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);

        // cancel with zero credit stays IDLE; coin+cancel adds first
        step("c0_can",  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        step("c1_acan", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1);
        step("c1_cack", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 2'd0, 1'b0, 0);

        // cancel beats vend at credit 4; two coins of 2 with a one-cycle gap
        step("c2_b",    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        step("c2_bcan", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd4, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1);
        step("c2_ack1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
        step("c2_rereq",1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1);
        step("c2_ack2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);

        // vend with delayed ack: coin refused, cancel and stray chg_ack ignored
        step("s5_a",    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        step("s5_b",    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
        step("s5_rej",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1);
        step("s5_can",  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
        step("s5_cack", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
        step("s5_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
        step("s5_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
        step("s5_iack", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);

        // enter CHANGE at credit 2, refuse a coin there, then reset asynchronously
        step("s6_b",    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        step("s6_can",  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1);
        step("s6_rej",  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b1, 2'd2, 1'b1, 1'b1);
        coin_b = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        exp_q.push_back(10'd0);
        check("s6_async_rst");
        @(posedge clk);
        #1;
        exp_q.push_back(10'd0);
        check("s6_rst_held");
        rst = 1'b1;
        step("s6_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        step("s6_a",    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
